// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port synchronous video RAM between the LCD scan
//            read path (absolute priority) and a pixel writer. Writer words
//            are buffered in a small FIFO and drained on cycles the LCD is not
//            reading. A fill engine clears the whole frame to one colour.
// Ports    : clk, rst_n              - clock, asynchronous active-low reset
//            i_lcd_en/i_lcd_addr     - LCD read request and address
//            o_lcd_data              - LCD read data (RAM pass-through)
//            i_wr_valid/addr/data    - writer handshake, o_wr_ready = accept
//            i_fill_start/color      - frame fill request and colour
//            o_fill_done             - pulse one cycle after last fill write
//            o_busy                  - draining, filling or FIFO non-empty
//            o_ram_addr/data/we      - RAM port, i_ram_data - RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int AW     = 14,
    parameter int DW     = 16,
    parameter int NWORDS = 12288,
    parameter int FDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_lcd_en,
    input  logic [AW-1:0] i_lcd_addr,
    output logic [DW-1:0] o_lcd_data,
    input  logic          i_wr_valid,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    input  logic          i_fill_start,
    input  logic [DW-1:0] i_fill_color,
    output logic          o_fill_done,
    output logic          o_busy,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_data,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_data
);

    localparam int            C_PW    = $clog2(FDEPTH);
    localparam logic [1:0]    C_IDLE  = 2'd0;
    localparam logic [1:0]    C_DRAIN = 2'd1;
    localparam logic [1:0]    C_FILL  = 2'd2;
    localparam logic [AW-1:0] C_LAST  = AW'(NWORDS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [C_PW:0] r_wptr;
    logic [C_PW:0] r_rptr;
    logic [C_PW:0] w_wptr_nxt;
    logic [C_PW:0] w_rptr_nxt;
    logic [AW-1:0] r_fifo_addr [FDEPTH];
    logic [DW-1:0] r_fifo_data [FDEPTH];

    logic [AW-1:0] r_fill_cnt;
    logic [DW-1:0] r_fill_color;
    logic          r_fill_done;

    logic          w_empty;
    logic          w_full;
    logic          w_empty_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_fill_we;
    logic          w_fill_last;
    logic          w_fill_accept;

    // ------------------------------------------------------------------
    // FIFO status: extra pointer MSB distinguishes full from empty
    // ------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_PW] != r_rptr[C_PW]) &&
                     (r_wptr[C_PW-1:0] == r_rptr[C_PW-1:0]);

    assign w_pop         = (r_state == C_DRAIN) && !i_lcd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign o_wr_ready    = (!w_full || w_pop) && (r_state != C_FILL);
    assign w_push        = i_wr_valid && o_wr_ready;
    assign w_fill_accept = (r_state == C_IDLE) && w_empty && i_fill_start;
    assign w_fill_we     = (r_state == C_FILL) && !i_lcd_en;
    assign w_fill_last   = w_fill_we && (r_fill_cnt == C_LAST);

    assign w_wptr_nxt  = r_wptr + {{C_PW{1'b0}}, w_push};
    assign w_rptr_nxt  = r_rptr + {{C_PW{1'b0}}, w_pop};
    assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = C_DRAIN;
                end else if (w_fill_accept) begin
                    w_state_nxt = C_FILL;
                end
            end
            C_DRAIN: begin
                if (w_empty_nxt) begin
                    w_state_nxt = C_IDLE;
                end
            end
            C_FILL: begin
                if (w_fill_last) begin
                    w_state_nxt = C_IDLE;
                end
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / RAM port mux (LCD read wins, writes are held)
    // ------------------------------------------------------------------
    always_comb begin
        o_ram_addr = '0;
        o_ram_data = '0;
        o_ram_we   = 1'b0;
        if (i_lcd_en) begin
            o_ram_addr = i_lcd_addr;
        end else if (w_pop) begin
            o_ram_addr = r_fifo_addr[r_rptr[C_PW-1:0]];
            o_ram_data = r_fifo_data[r_rptr[C_PW-1:0]];
            o_ram_we   = 1'b1;
        end else if (w_fill_we) begin
            o_ram_addr = r_fill_cnt;
            o_ram_data = r_fill_color;
            o_ram_we   = 1'b1;
        end
    end

    assign o_lcd_data  = i_ram_data;
    assign o_fill_done = r_fill_done;
    assign o_busy      = (r_state != C_IDLE) || !w_empty;

    // ------------------------------------------------------------------
    // FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
        end
    end

    // FIFO storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[C_PW-1:0]] <= i_wr_addr;
            r_fifo_data[r_wptr[C_PW-1:0]] <= i_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Fill engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt   <= '0;
            r_fill_color <= '0;
            r_fill_done  <= 1'b0;
        end else begin
            r_fill_done <= w_fill_last;
            if (w_fill_accept) begin
                r_fill_color <= i_fill_color;
            end
            if (w_fill_last) begin
                r_fill_cnt <= '0;
            end else if (w_fill_we) begin
                r_fill_cnt <= r_fill_cnt + AW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Directed self-checking bench for vram_arbiter with a behavioural
//            single-port read-first RAM (1-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_lcd_en;
    logic [13:0] i_lcd_addr;
    logic [15:0] o_lcd_data;
    logic        i_wr_valid;
    logic [13:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic        o_wr_ready;
    logic        i_fill_start;
    logic [15:0] i_fill_color;
    logic        o_fill_done;
    logic        o_busy;
    logic [13:0] o_ram_addr;
    logic [15:0] o_ram_data;
    logic        o_ram_we;
    logic [15:0] r_ram_rd;
    logic [15:0] r_ram [16384];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(14), .DW(16), .NWORDS(12288), .FDEPTH(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lcd_en     (i_lcd_en),
        .i_lcd_addr   (i_lcd_addr),
        .o_lcd_data   (o_lcd_data),
        .i_wr_valid   (i_wr_valid),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .i_fill_start (i_fill_start),
        .i_fill_color (i_fill_color),
        .o_fill_done  (o_fill_done),
        .o_busy       (o_busy),
        .o_ram_addr   (o_ram_addr),
        .o_ram_data   (o_ram_data),
        .o_ram_we     (o_ram_we),
        .i_ram_data   (r_ram_rd)
    );

    // Behavioural RAM; known words are planted while reset is held.
    always @(posedge clk) begin
        r_ram_rd <= r_ram[o_ram_addr];
        if (!rst_n) begin
            r_ram[5]   <= 16'h1234;
            r_ram[100] <= 16'h0BEE;
        end else if (o_ram_we) begin
            r_ram[o_ram_addr] <= o_ram_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checks.
    task automatic drive(input logic lcd, input logic [13:0] la, input logic v,
                         input logic [13:0] wa, input logic [15:0] wd, input logic fs);
        @(negedge clk);
        i_lcd_en     = lcd;
        i_lcd_addr   = la;
        i_wr_valid   = v;
        i_wr_addr    = wa;
        i_wr_data    = wd;
        i_fill_start = fs;
        #1;
    endtask

    initial begin
        int addr_exp;
        int stalls;
        int bad_wr;
        int bad_stall;
        int bad_rdy;
        int bad_done;

        rst_n        = 1'b0;
        i_fill_color = 16'hF800;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // ---------------- reset values ----------------
        chk("rst_we",    o_ram_we,    0);
        chk("rst_ready", o_wr_ready,  1);
        chk("rst_busy",  o_busy,      0);
        chk("rst_done",  o_fill_done, 0);
        chk("rst_addr",  o_ram_addr,  0);
        chk("rst_data",  o_ram_data,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- LCD read, 1-cycle latency ----------------
        drive(1, 5, 0, 0, 0, 0);
        chk("rd_addr", o_ram_addr, 5);
        chk("rd_we",   o_ram_we,   0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rd_data", o_lcd_data, 16'h1234);

        // ---------------- fill FIFO while LCD reads ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1, 14'(200 + i), 1, 14'(i), 16'(16'h00A0 + i), 0);
            chk("t2_ready", o_wr_ready, 1);
            chk("t2_held",  o_ram_we,   0);
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("t2_full_ready", o_wr_ready, 0);
        chk("t2_full_busy",  o_busy,     1);
        chk("t2_full_we",    o_ram_we,   0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("t2_we",   o_ram_we,   1);
            chk("t2_addr", o_ram_addr, 32'(i));
            chk("t2_data", o_ram_data, 32'(16'h00A0 + i));
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_idle_busy", o_busy,   0);
        chk("t2_idle_we",   o_ram_we, 0);
        chk("t2_ram3",      r_ram[3], 16'h00A3);

        // ---------------- LCD toggling during drain ----------------
        drive(1, 50, 1, 10, 16'h00B0, 0);
        drive(1, 51, 1, 11, 16'h00B1, 0);
        drive(1, 100, 0, 0, 0, 0);
        chk("t3_rd_we",   o_ram_we,   0);
        chk("t3_rd_addr", o_ram_addr, 100);
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_wr0_addr", o_ram_addr, 10);
        chk("t3_wr0_data", o_ram_data, 16'h00B0);
        chk("t3_lcd_data", o_lcd_data, 16'h0BEE);
        drive(1, 101, 0, 0, 0, 0);
        chk("t3_rd2_we",   o_ram_we,   0);
        chk("t3_rd2_addr", o_ram_addr, 101);
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_wr1_we",   o_ram_we,   1);
        chk("t3_wr1_addr", o_ram_addr, 11);
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_idle", o_busy, 0);

        // ---------------- full FIFO, push and pop together ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 14'(20 + i), 16'(16'h00C0 + i), 0);
        end
        drive(0, 0, 1, 24, 16'h00C4, 0);
        chk("t4_ready_pop", o_wr_ready, 1);
        chk("t4_addr20",    o_ram_addr, 20);
        for (int i = 1; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("t4_we",   o_ram_we,   1);
            chk("t4_addr", o_ram_addr, 32'(20 + i));
            chk("t4_data", o_ram_data, 32'(16'h00C0 + i));
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_idle", o_busy, 0);

        // ---------------- fill start ignored while FIFO non-empty ----------------
        drive(1, 0, 1, 30, 16'h0055, 0);
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_wr_addr", o_ram_addr, 30);
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_no_fill_we",   o_ram_we, 0);
        chk("t5_no_fill_busy", o_busy,   0);

        // ---------------- full frame fill with a short stall ----------------
        drive(0, 0, 0, 0, 0, 1);
        chk("t6_start_ready", o_wr_ready, 1);
        addr_exp  = 0;
        stalls    = 0;
        bad_wr    = 0;
        bad_stall = 0;
        bad_rdy   = 0;
        bad_done  = 0;
        while (addr_exp < 12288) begin
            if (addr_exp == 50 && stalls < 3) begin
                drive(1, 7, 1, 0, 0, 0);
                stalls++;
                if (o_ram_we !== 1'b0 || o_ram_addr !== 14'd7) bad_stall++;
            end else begin
                drive(0, 0, 1, 0, 0, 0);
                if (o_ram_we !== 1'b1 || o_ram_addr !== 14'(addr_exp) ||
                    o_ram_data !== 16'hF800) bad_wr++;
                addr_exp++;
            end
            if (o_wr_ready !== 1'b0) bad_rdy++;
            if (o_fill_done !== 1'b0) bad_done++;
        end
        chk("t6_fill_writes", 32'(bad_wr),    0);
        chk("t6_fill_stall",  32'(bad_stall), 0);
        chk("t6_fill_ready",  32'(bad_rdy),   0);
        chk("t6_early_done",  32'(bad_done),  0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_done_pulse", o_fill_done, 1);
        chk("t6_done_we",    o_ram_we,    0);
        chk("t6_done_busy",  o_busy,      0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_done_once", o_fill_done, 0);
        chk("t6_ram_first", r_ram[0],     16'hF800);
        chk("t6_ram_last",  r_ram[12287], 16'hF800);

        // ---------------- reset in the middle of a fill ----------------
        i_fill_color = 16'h07E0;
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t7_at100_we",   o_ram_we,   1);
        chk("t7_at100_addr", o_ram_addr, 100);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_we",    o_ram_we,   0);
        chk("t7_rst_busy",  o_busy,     0);
        chk("t7_rst_ready", o_wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("t7_post_we",   o_ram_we,    0);
        chk("t7_post_done", o_fill_done, 0);
        chk("t7_post_busy", o_busy,      0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("t7_restart_we",   o_ram_we,   1);
        chk("t7_restart_addr", o_ram_addr, 0);
        chk("t7_restart_data", o_ram_data, 16'h07E0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
